overlay_scheduler: RTL and testbench
====================================

Name: overlay_scheduler

Overview:
- Per-pixel layer scheduler in front of the VGA colorizer.
- Resolves the six 2-bit icon overlay layers plus the world-map pixel into one winning 2-bit code and a source-layer ID, using a programmable priority order, per-layer enables and frame-synchronous blink gating. The blink gating flashes active sprinklers.
- Configuration is written at any time through a req/ack handshake and committed only at frame start, so no frame ever shows a torn priority change.

Parameters:
- BLINK_FRAMES, 30, number of frame_start pulses per blink half-period (legal range 1..255).
- NUM_LAYERS, 6, number of icon layers (fixed at 6; not for override).

Ports:
- clock  in  1  pixel clock, 75 MHz
- reset  in  1  asynchronous, active-high reset
- video_on  in  1  active-video flag from the display timing generator
- frame_start  in  1  one-cycle pulse at start of vertical blank
- world_pixel  in  2  world-map pixel code
- icon_bus  in  12  six icon layer codes; layer k = bits [2k+1:2k]; code 00 = transparent
- cfg_wr  in  1  config write request; held high until cfg_ack
- cfg_prio  in  18  six 3-bit layer indices; slot 0 = bits [2:0] = highest priority
- cfg_enable  in  6  per-layer enable, bit k = layer k
- cfg_blink  in  6  per-layer blink select
- cfg_ack  out  1  one-cycle pulse when a config is committed
- pix_code  out  2  resolved pixel code to the colorizer
- pix_layer  out  3  winning layer 0..5; 7 = world map
- pix_valid  out  1  video_on delayed to align with pix_code
- blink_phase  out  1  current blink phase; 1 = blink layers hidden

Behaviour:
- Reset (async, any time):
  - Outputs: pix_code=00, pix_layer=7, pix_valid=0, cfg_ack=0, blink_phase=0.
  - Active config: prio slot i = layer i, enable=6'b111111, blink=0.
  - Pending config is discarded, frame counter=0, pipeline cleared.
- Config handshake:
  - States: IDLE and PENDING.
  - IDLE & cfg_wr: capture cfg_prio/enable/blink into shadow registers and go to PENDING.
  - PENDING & frame_start: copy shadow into active registers, pulse cfg_ack for 1 cycle the next cycle, go to IDLE.
  - cfg_wr while PENDING is ignored; the shadow is not overwritten.
  - The requester drops cfg_wr after cfg_ack. If cfg_wr is still high the cycle after cfg_ack, it is a new request.
  - cfg_wr and frame_start in the same cycle while IDLE: capture now, commit at the next frame_start.
- Priority rules:
  - A slot index greater than 5 is an empty slot and never wins.
  - Duplicate indices are allowed; the lowest slot holding the index takes it.
  - A layer absent from all slots never wins.
- Blink:
  - An 8-bit counter increments on each frame_start.
  - When the counter reaches BLINK_FRAMES-1, the next frame_start sets it to 0 and toggles blink_phase.
  - BLINK_FRAMES=1 toggles blink_phase on every frame_start.
  - The blink update and a config commit on the same frame_start both take effect.
- Effective mask = active_enable & ~(active_blink & {6{blink_phase}}).
- Pixel pipeline, fixed 2-cycle latency from inputs to pix_*:
  - Stage 1 registers icon_bus, world_pixel, video_on, the effective mask and the priority.
  - Stage 2 scans slots 0..5. The first slot whose layer index is ≤5, is masked in and has a nonzero code wins: pix_code = that code, pix_layer = that index.
  - No winner: pix_code = world_pixel, pix_layer = 7.
  - If the stage-1 video_on is 0: pix_code=00, pix_layer=7, pix_valid=0.
- A config or blink change made on the frame_start cycle applies to pixels sampled from the following cycle onward. Pixels already in flight keep the old config.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset defaults: after reset, video_on=1, icon_bus=12'h000, world_pixel=10 -> 2 cycles later pix_code=10, pix_layer=7, pix_valid=1.
- Default priority: icon_bus layer1=01, layer4=11 -> pix_code=01, pix_layer=1. Then commit cfg_prio with slot0=4 -> pix_code=11, pix_layer=4, only after a frame_start and cfg_ack.
- Handshake:
  - cfg_wr held 3 cycles with no frame_start -> no cfg_ack, pixels unchanged.
  - A second cfg_wr with different data while PENDING -> the first data is committed on frame_start.
  - cfg_ack is high exactly 1 cycle.
- Blink, BLINK_FRAMES=2, cfg_blink=6'b000001, layer0=11 -> visible for 2 frames, then world_pixel shown (pix_layer=7) for 2 frames, with blink_phase toggling every 2 frame_starts.
- Masking and illegal slots: cfg_enable=6'b111110 with layer0=10 -> falls through to world_pixel. Setting all slots to 7 -> always world_pixel.
- Asynchronous reset and video gating:
  - Reset asserted mid-frame while PENDING -> all outputs at reset values immediately, no cfg_ack after release, default priority restored.
  - video_on=0 -> pix_code=00, pix_valid=0 after 2 cycles.

Source files
------------

// File: rtl/overlay_scheduler_if.sv
// Pixel, timing and configuration signals between the display front end and overlay_scheduler.
// The master drives video timing, layer codes and config requests; the slave returns the resolved pixel.
interface overlay_scheduler_if;
  logic        video_on;
  logic        frame_start;
  logic [1:0]  world_pixel;
  logic [11:0] icon_bus;
  logic        cfg_wr;
  logic [17:0] cfg_prio;
  logic [5:0]  cfg_enable;
  logic [5:0]  cfg_blink;
  logic        cfg_ack;
  logic [1:0]  pix_code;
  logic [2:0]  pix_layer;
  logic        pix_valid;
  logic        blink_phase;

  modport master (
    output video_on, frame_start, world_pixel, icon_bus,
    output cfg_wr, cfg_prio, cfg_enable, cfg_blink,
    input  cfg_ack, pix_code, pix_layer, pix_valid, blink_phase
  );

  modport slave (
    input  video_on, frame_start, world_pixel, icon_bus,
    input  cfg_wr, cfg_prio, cfg_enable, cfg_blink,
    output cfg_ack, pix_code, pix_layer, pix_valid, blink_phase
  );
endinterface

// File: rtl/overlay_scheduler.sv
// Per-pixel layer scheduler: picks the winning icon layer or the world map through a
// programmable priority order, with frame-committed config and frame-synchronous blink.
//
// state       | meaning
// CFG_IDLE    | no pending config; a new cfg_wr is captured into the shadow registers
// CFG_PENDING | shadow holds a config waiting for the next frame_start to commit
module overlay_scheduler #(
  parameter int BLINK_FRAMES = 30,
  parameter int NUM_LAYERS   = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  overlay_scheduler_if.slave   bus
);

  localparam logic [3*NUM_LAYERS-1:0] DEFAULT_PRIO = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [7:0]              BLINK_LAST   = 8'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  cfg_state_t state, state_nxt;
  logic       capture;
  logic       commit;
  logic       cfg_ack_q;

  logic [3*NUM_LAYERS-1:0] shadow_prio;
  logic [NUM_LAYERS-1:0]   shadow_enable;
  logic [NUM_LAYERS-1:0]   shadow_blink;
  logic [3*NUM_LAYERS-1:0] active_prio;
  logic [NUM_LAYERS-1:0]   active_enable;
  logic [NUM_LAYERS-1:0]   active_blink;

  logic [7:0]              frame_cnt;
  logic                    blink_phase_q;
  logic [NUM_LAYERS-1:0]   eff_mask;

  logic [2*NUM_LAYERS-1:0] s1_icon;
  logic [1:0]              s1_world;
  logic                    s1_video;
  logic [NUM_LAYERS-1:0]   s1_mask;
  logic [3*NUM_LAYERS-1:0] s1_prio;

  logic                    win_found;
  logic [1:0]              win_code;
  logic [2:0]              win_layer;
  logic [2:0]              slot_idx;

  logic [1:0]              pix_code_q;
  logic [2:0]              pix_layer_q;
  logic                    pix_valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CFG_IDLE;
    else       state <= state_nxt;
  end

  // The cycle cfg_ack is high still carries the old request, so it must not be recaptured.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (bus.cfg_wr && !cfg_ack_q) begin
          capture   = 1'b1;
          state_nxt = CFG_PENDING;
        end
      end
      CFG_PENDING: begin
        if (bus.frame_start) begin
          commit    = 1'b1;
          state_nxt = CFG_IDLE;
        end
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_prio   <= DEFAULT_PRIO;
      shadow_enable <= '1;
      shadow_blink  <= '0;
    end else if (capture) begin
      shadow_prio   <= bus.cfg_prio;
      shadow_enable <= bus.cfg_enable;
      shadow_blink  <= bus.cfg_blink;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_prio   <= DEFAULT_PRIO;
      active_enable <= '1;
      active_blink  <= '0;
      cfg_ack_q     <= 1'b0;
    end else begin
      cfg_ack_q <= commit;
      if (commit) begin
        active_prio   <= shadow_prio;
        active_enable <= shadow_enable;
        active_blink  <= shadow_blink;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt     <= 8'd0;
      blink_phase_q <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt     <= 8'd0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign eff_mask = active_enable & ~(active_blink & {NUM_LAYERS{blink_phase_q}});

  // Stage 1 snapshots the config alongside the pixel so in-flight pixels keep the old config.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_icon  <= '0;
      s1_world <= 2'b00;
      s1_video <= 1'b0;
      s1_mask  <= '0;
      s1_prio  <= DEFAULT_PRIO;
    end else begin
      s1_icon  <= bus.icon_bus;
      s1_world <= bus.world_pixel;
      s1_video <= bus.video_on;
      s1_mask  <= eff_mask;
      s1_prio  <= active_prio;
    end
  end

  // Indices 6 and 7 match no layer, so such slots are simply skipped.
  always_comb begin
    win_found = 1'b0;
    win_code  = s1_world;
    win_layer = 3'd7;
    slot_idx  = 3'd0;
    for (int slot = 0; slot < NUM_LAYERS; slot++) begin
      slot_idx = s1_prio[3*slot +: 3];
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (!win_found && slot_idx == 3'(k) && s1_mask[k] && s1_icon[2*k +: 2] != 2'b00) begin
          win_found = 1'b1;
          win_code  = s1_icon[2*k +: 2];
          win_layer = 3'(k);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_code_q  <= 2'b00;
      pix_layer_q <= 3'd7;
      pix_valid_q <= 1'b0;
    end else if (!s1_video) begin
      pix_code_q  <= 2'b00;
      pix_layer_q <= 3'd7;
      pix_valid_q <= 1'b0;
    end else begin
      pix_code_q  <= win_code;
      pix_layer_q <= win_layer;
      pix_valid_q <= 1'b1;
    end
  end

  assign bus.cfg_ack     = cfg_ack_q;
  assign bus.pix_code    = pix_code_q;
  assign bus.pix_layer   = pix_layer_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.blink_phase = blink_phase_q;

endmodule

// File: tb/tb_overlay_scheduler.sv
// Scoreboard bench for overlay_scheduler: directed pixel vectors push hand-computed results
// into a queue that a monitor drains two cycles later; config/blink state is checked directly.
module tb_overlay_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ack_count = 0;
  logic ack_prev = 1'b0;

  typedef struct {
    int         due;
    logic [1:0] code;
    logic [2:0] layer;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [17:0] PRIO_DEF = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [17:0] PRIO_A   = {3'd5, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
  localparam logic [17:0] PRIO_ALL7 = 18'h3FFFF;
  localparam logic [17:0] PRIO_G   = {3'd7, 3'd7, 3'd7, 3'd7, 3'd2, 3'd6};

  overlay_scheduler_if bus();

  overlay_scheduler #(.BLINK_FRAMES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (bus.cfg_ack) begin
        checks++;
        ack_count++;
        if (ack_prev) begin
          errors++;
          $display("FAIL cfg_ack_width: got high 2+ cycles, exp 1 cycle (cyc %0d)", cyc);
        end
      end
      ack_prev = bus.cfg_ack;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if (mon_e.due != cyc) begin
          errors++;
          $display("FAIL pixel_stale: got no output at due cyc %0d, now %0d", mon_e.due, cyc);
        end else if (bus.pix_code !== mon_e.code || bus.pix_layer !== mon_e.layer ||
                     bus.pix_valid !== mon_e.valid) begin
          errors++;
          $display("FAIL pixel@cyc%0d: got code=%b layer=%0d valid=%b, exp code=%b layer=%0d valid=%b",
                   cyc, bus.pix_code, bus.pix_layer, bus.pix_valid,
                   mon_e.code, mon_e.layer, mon_e.valid);
        end
      end
    end else begin
      ack_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, exp %0d", name, got, exp_v);
    end
  endtask

  task automatic set_cfg(input logic [17:0] p, input logic [5:0] en, input logic [5:0] bl);
    bus.cfg_prio   = p;
    bus.cfg_enable = en;
    bus.cfg_blink  = bl;
  endtask

  task automatic step(input logic [11:0] icon, input logic [1:0] world, input logic vid,
                      input logic fs, input logic wr,
                      input logic [1:0] ec, input logic [2:0] el, input logic ev);
    exp_t e;
    @(negedge clock);
    bus.icon_bus    = icon;
    bus.world_pixel = world;
    bus.video_on    = vid;
    bus.frame_start = fs;
    bus.cfg_wr      = wr;
    e.due   = cyc + 2;
    e.code  = ec;
    e.layer = el;
    e.valid = ev;
    sb.push_back(e);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pix_code", 32'(bus.pix_code), 0);
    chk("arst_pix_layer", 32'(bus.pix_layer), 7);
    chk("arst_pix_valid", 32'(bus.pix_valid), 0);
    chk("arst_cfg_ack", 32'(bus.cfg_ack), 0);
    chk("arst_blink_phase", 32'(bus.blink_phase), 0);
    sb.delete();
    bus.cfg_wr      = 1'b0;
    bus.frame_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.video_on    = 1'b0;
    bus.frame_start = 1'b0;
    bus.world_pixel = 2'b00;
    bus.icon_bus    = 12'h000;
    bus.cfg_wr      = 1'b0;
    set_cfg(PRIO_DEF, 6'h3F, 6'h00);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_pix_code", 32'(bus.pix_code), 0);
    chk("rst_pix_layer", 32'(bus.pix_layer), 7);
    chk("rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("rst_cfg_ack", 32'(bus.cfg_ack), 0);
    chk("rst_blink_phase", 32'(bus.blink_phase), 0);
    reset = 1'b0;

    // reset defaults: world shows through
    step(12'h000, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    step(12'h000, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    // default priority: layer1 beats layer4
    step(12'h304, 2'b10, 1, 0, 0, 2'b01, 3'd1, 1);
    step(12'h304, 2'b10, 1, 0, 0, 2'b01, 3'd1, 1);

    // request A held 3 cycles, no frame_start
    set_cfg(PRIO_A, 6'h3F, 6'h00);
    repeat (3) step(12'h304, 2'b10, 1, 0, 1, 2'b01, 3'd1, 1);
    chk("ack_none_before_frame", ack_count, 0);
    // different data while pending must be ignored
    set_cfg(PRIO_ALL7, 6'h00, 6'h00);
    step(12'h304, 2'b10, 1, 0, 1, 2'b01, 3'd1, 1);
    step(12'h304, 2'b10, 1, 1, 1, 2'b01, 3'd1, 1);
    // ack cycle with cfg_wr still high: not a new request
    step(12'h304, 2'b10, 1, 0, 1, 2'b11, 3'd4, 1);
    step(12'h304, 2'b10, 1, 0, 0, 2'b11, 3'd4, 1);
    step(12'h304, 2'b10, 1, 1, 0, 2'b11, 3'd4, 1);
    step(12'h304, 2'b10, 1, 0, 0, 2'b11, 3'd4, 1);
    chk("ack_count_first", ack_count, 1);
    chk("blink_phase_after_2fs", 32'(bus.blink_phase), 1);

    // reset while pending discards the request and restores default priority
    set_cfg(PRIO_A, 6'h3F, 6'h00);
    step(12'h304, 2'b10, 1, 0, 1, 2'b11, 3'd4, 1);
    async_reset();
    step(12'h304, 2'b10, 1, 1, 0, 2'b01, 3'd1, 1);
    step(12'h304, 2'b10, 1, 0, 0, 2'b01, 3'd1, 1);
    step(12'h304, 2'b10, 1, 1, 0, 2'b01, 3'd1, 1);
    step(12'h304, 2'b10, 1, 0, 0, 2'b01, 3'd1, 1);
    chk("ack_none_after_reset", ack_count, 1);
    chk("blink_phase_post_reset", 32'(bus.blink_phase), 1);

    // blink layer0, phase currently 1
    set_cfg(PRIO_DEF, 6'h3F, 6'h01);
    step(12'h003, 2'b10, 1, 0, 1, 2'b11, 3'd0, 1);
    step(12'h003, 2'b10, 1, 1, 1, 2'b11, 3'd0, 1);
    step(12'h003, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    step(12'h003, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    chk("ack_count_blink", ack_count, 2);
    chk("blink_phase_hidden", 32'(bus.blink_phase), 1);
    step(12'h003, 2'b10, 1, 1, 0, 2'b10, 3'd7, 1);
    step(12'h003, 2'b10, 1, 0, 0, 2'b11, 3'd0, 1);
    chk("blink_phase_shown", 32'(bus.blink_phase), 0);
    step(12'h003, 2'b10, 1, 0, 0, 2'b11, 3'd0, 1);
    step(12'h003, 2'b10, 1, 1, 0, 2'b11, 3'd0, 1);
    step(12'h003, 2'b10, 1, 0, 0, 2'b11, 3'd0, 1);
    step(12'h003, 2'b10, 1, 1, 0, 2'b11, 3'd0, 1);
    step(12'h003, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    chk("blink_phase_hidden2", 32'(bus.blink_phase), 1);
    step(12'h003, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);

    // layer0 disabled falls through
    set_cfg(PRIO_DEF, 6'h3E, 6'h00);
    step(12'h002, 2'b01, 1, 0, 1, 2'b01, 3'd7, 1);
    step(12'h002, 2'b01, 1, 1, 1, 2'b01, 3'd7, 1);
    step(12'h002, 2'b01, 1, 0, 0, 2'b01, 3'd7, 1);
    step(12'h002, 2'b01, 1, 0, 0, 2'b01, 3'd7, 1);
    step(12'h00A, 2'b01, 1, 0, 0, 2'b10, 3'd1, 1);
    chk("ack_count_mask", ack_count, 3);

    // all slots empty: world always
    set_cfg(PRIO_ALL7, 6'h3F, 6'h00);
    step(12'hFFF, 2'b10, 1, 0, 1, 2'b11, 3'd1, 1);
    step(12'hFFF, 2'b10, 1, 1, 1, 2'b11, 3'd1, 1);
    step(12'hFFF, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    step(12'hFFF, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    chk("ack_count_all7", ack_count, 4);

    // slot0 illegal, slot1 = layer2, rest empty
    set_cfg(PRIO_G, 6'h3F, 6'h00);
    step(12'hFDF, 2'b10, 1, 0, 1, 2'b10, 3'd7, 1);
    step(12'hFDF, 2'b10, 1, 1, 1, 2'b10, 3'd7, 1);
    step(12'hFDF, 2'b10, 1, 0, 0, 2'b01, 3'd2, 1);
    step(12'hFCF, 2'b10, 1, 0, 0, 2'b10, 3'd7, 1);
    chk("ack_count_slots", ack_count, 5);

    // video gating
    step(12'hFDF, 2'b10, 0, 0, 0, 2'b00, 3'd7, 0);
    step(12'hFDF, 2'b10, 1, 0, 0, 2'b01, 3'd2, 1);
    step(12'hFDF, 2'b11, 0, 0, 0, 2'b00, 3'd7, 0);
    step(12'h000, 2'b11, 1, 0, 0, 2'b11, 3'd7, 1);

    repeat (4) @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
